// File: rtl/lc3_controller.sv
// LC-3 multicycle control FSM: fetch/decode/execute/memory/writeback/update-PC.
// Define LC3_INDIRECT_EN to enable two-access LDI/STI; otherwise they retire as illegal NOPs.
module lc3_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] IR,
    input  logic [2:0]  nzp,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        enable_updatePC,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        dmem_addr_sel,
    output logic [5:0]  E_control,
    output logic        br_taken,
    output logic        illegal,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM_RD    = 3'd3,
        S_MEM_WR    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_UPDATE_PC = 3'd6
    } state_t;

    localparam logic [3:0] OP_BR  = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_LD  = 4'h2;
    localparam logic [3:0] OP_ST  = 4'h3;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_LDR = 4'h6;
    localparam logic [3:0] OP_STR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h9;
    localparam logic [3:0] OP_LDI = 4'hA;
    localparam logic [3:0] OP_STI = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_LEA = 4'hE;

    state_t     r_state;
    state_t     w_next;
    state_t     w_exec_next;
    logic [3:0] w_op;
    logic [5:0] w_ec;
    logic       w_ill;
    logic       w_unused;

    assign w_op     = IR[15:12];
    assign w_unused = ^{IR[8:6], IR[4:0]};

    // Per-opcode Execute control, illegal flag and post-EXECUTE destination
    always_comb begin
        w_ec        = 6'b000000;
        w_ill       = 1'b0;
        w_exec_next = S_UPDATE_PC;
        case (w_op)
            OP_ADD: begin
                w_ec        = {5'b00000, IR[5]};
                w_exec_next = S_WRITEBACK;
            end
            OP_AND: begin
                w_ec        = {5'b01000, IR[5]};
                w_exec_next = S_WRITEBACK;
            end
            OP_NOT: begin
                w_ec        = 6'b100000;
                w_exec_next = S_WRITEBACK;
            end
            OP_LEA: begin
                w_ec        = 6'b000100;
                w_exec_next = S_WRITEBACK;
            end
            OP_LD: begin
                w_ec        = 6'b000100;
                w_exec_next = S_MEM_RD;
            end
            OP_LDR: begin
                w_ec        = 6'b000010;
                w_exec_next = S_MEM_RD;
            end
            OP_ST: begin
                w_ec        = 6'b000100;
                w_exec_next = S_MEM_WR;
            end
            OP_STR: begin
                w_ec        = 6'b000010;
                w_exec_next = S_MEM_WR;
            end
            OP_LDI, OP_STI: begin
                w_ec        = 6'b000100;
`ifdef LC3_INDIRECT_EN
                w_exec_next = S_MEM_RD;
`else
                w_ill       = 1'b1;
`endif
            end
            OP_BR:   w_ec = 6'b000100;
            OP_JMP:  w_ec = 6'b001110;
            default: w_ill = 1'b1;
        endcase
    end

`ifdef LC3_INDIRECT_EN
    logic r_ind;
    logic w_first_ack;

    // Pointer fetch of LDI/STI completes: second access uses the fetched pointer
    assign w_first_ack = (r_state == S_MEM_RD) && dmem_ack && !r_ind &&
                         (w_op == OP_LDI || w_op == OP_STI);

    always_ff @(posedge clock) begin
        if (!reset)
            r_ind <= 1'b0;
        else if (r_state == S_EXECUTE)
            r_ind <= 1'b0;
        else if (w_first_ack)
            r_ind <= 1'b1;
    end

    assign dmem_addr_sel = reset && r_ind;
`else
    assign dmem_addr_sel = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:     if (imem_ack) w_next = S_DECODE;
            S_DECODE:    w_next = S_EXECUTE;
            S_EXECUTE:   w_next = w_exec_next;
            S_MEM_RD: begin
                if (dmem_ack) begin
                    w_next = S_WRITEBACK;
`ifdef LC3_INDIRECT_EN
                    if (w_first_ack)
                        w_next = (w_op == OP_LDI) ? S_MEM_RD : S_MEM_WR;
`endif
                end
            end
            S_MEM_WR:    if (dmem_ack) w_next = S_UPDATE_PC;
            S_WRITEBACK: w_next = S_UPDATE_PC;
            S_UPDATE_PC: w_next = S_FETCH;
            default:     w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset)
            r_state <= S_FETCH;
        else
            r_state <= w_next;
    end

    assign enable_fetch     = reset && (r_state == S_FETCH);
    assign imem_req         = reset && (r_state == S_FETCH);
    assign enable_decode    = reset && (r_state == S_DECODE);
    assign enable_execute   = reset && (r_state == S_EXECUTE);
    assign enable_writeback = reset && (r_state == S_WRITEBACK);
    assign enable_updatePC  = reset && (r_state == S_UPDATE_PC);
    assign dmem_req         = reset && (r_state == S_MEM_RD ||
                                        r_state == S_MEM_WR);
    assign dmem_we          = reset && (r_state == S_MEM_WR);
    assign illegal          = reset && (r_state == S_EXECUTE) && w_ill;
    assign br_taken         = reset && (r_state == S_UPDATE_PC) &&
                              ((w_op == OP_JMP) ||
                               (w_op == OP_BR && |(IR[11:9] & nzp)));
    assign E_control        = w_ec;
    assign state            = r_state;

endmodule

// File: tb/tb_lc3_controller.sv
// Scoreboard bench for lc3_controller: per-cycle expected outputs queued
// by the stimulus, popped and compared by a negedge monitor.
module tb_lc3_controller;

    logic        clock;
    logic        reset;
    logic [15:0] IR;
    logic [2:0]  nzp;
    logic        imem_ack;
    logic        dmem_ack;
    logic        enable_fetch;
    logic        enable_decode;
    logic        enable_execute;
    logic        enable_writeback;
    logic        enable_updatePC;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_addr_sel;
    logic [5:0]  E_control;
    logic        br_taken;
    logic        illegal;
    logic [2:0]  state;

    lc3_controller dut (
        .clock            (clock),
        .reset            (reset),
        .IR               (IR),
        .nzp              (nzp),
        .imem_ack         (imem_ack),
        .dmem_ack         (dmem_ack),
        .enable_fetch     (enable_fetch),
        .enable_decode    (enable_decode),
        .enable_execute   (enable_execute),
        .enable_writeback (enable_writeback),
        .enable_updatePC  (enable_updatePC),
        .imem_req         (imem_req),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr_sel    (dmem_addr_sel),
        .E_control        (E_control),
        .br_taken         (br_taken),
        .illegal          (illegal),
        .state            (state)
    );

    // ctl = {en_f, en_d, en_e, en_wb, en_upc, imem_req, dmem_req, dmem_we, addr_sel, br_taken, illegal}
    localparam logic [10:0] C_0  = 11'b00000_000_0_00;
    localparam logic [10:0] C_F  = 11'b10000_100_0_00;
    localparam logic [10:0] C_D  = 11'b01000_000_0_00;
    localparam logic [10:0] C_E  = 11'b00100_000_0_00;
    localparam logic [10:0] C_EI = 11'b00100_000_0_01;
    localparam logic [10:0] C_W  = 11'b00010_000_0_00;
    localparam logic [10:0] C_U  = 11'b00001_000_0_00;
    localparam logic [10:0] C_UT = 11'b00001_000_0_10;
    localparam logic [10:0] C_R0 = 11'b00000_010_0_00;
    localparam logic [10:0] C_W0 = 11'b00000_011_0_00;
`ifdef LC3_INDIRECT_EN
    localparam logic [10:0] C_R1 = 11'b00000_010_1_00;
    localparam logic [10:0] C_W1 = 11'b00000_011_1_00;
    localparam logic [10:0] C_WA = 11'b00010_000_1_00;
    localparam logic [10:0] C_UA = 11'b00001_000_1_00;
`endif

    typedef struct packed {
        logic [15:0] id;
        logic [2:0]  st;
        logic [10:0] ctl;
        logic [5:0]  ec;
        logic        chk_ec;
    } exp_t;

    exp_t        q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc_id = 0;
    logic [15:0] ir_n;
    logic [2:0]  nzp_n;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [10:0] got;
            e   = q.pop_front();
            got = {enable_fetch, enable_decode, enable_execute,
                   enable_writeback, enable_updatePC, imem_req,
                   dmem_req, dmem_we, dmem_addr_sel, br_taken, illegal};
            n_chk++;
            if (state === e.st && got === e.ctl &&
                (!e.chk_ec || E_control === e.ec)) begin
                n_pass++;
            end else begin
                $display("FAIL cyc%0d: state=%0d ctl=%b ec=%b, want state=%0d ctl=%b ec=%b",
                         e.id, state, got, E_control, e.st, e.ctl, e.ec);
            end
        end
    end

    task automatic step(input logic r, input logic ia, input logic da,
                        input logic [2:0] st, input logic [10:0] ctl,
                        input logic [5:0] ec, input logic ce);
        exp_t e;
        @(posedge clock);
        #1;
        reset    = r;
        imem_ack = ia;
        dmem_ack = da;
        IR       = ir_n;
        nzp      = nzp_n;
        e.id     = cyc_id[15:0];
        e.st     = st;
        e.ctl    = ctl;
        e.ec     = ec;
        e.chk_ec = ce;
        q.push_back(e);
        cyc_id++;
    endtask

    task automatic go(input logic [2:0] st, input logic [10:0] ctl);
        step(1'b1, 1'b0, 1'b0, st, ctl, 6'b0, 1'b0);
    endtask

    task automatic fde(input logic [10:0] ectl, input logic [5:0] ec);
        step(1'b1, 1'b1, 1'b0, 3'd0, C_F, 6'b0, 1'b0);
        go(3'd1, C_D);
        step(1'b1, 1'b0, 1'b0, 3'd2, ectl, ec, 1'b1);
    endtask

    task automatic mem(input logic da, input logic [2:0] st,
                       input logic [10:0] ctl);
        step(1'b1, 1'b0, da, st, ctl, 6'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0; IR = 16'h0; nzp = 3'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        ir_n = 16'h0; nzp_n = 3'b0;
        repeat (2) @(posedge clock);

        step(1'b0, 1'b0, 1'b0, 3'd0, C_0, 6'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 3'd0, C_0, 6'b0, 1'b0);
        go(3'd0, C_F);
        go(3'd0, C_F);

        ir_n = 16'h1262;
        fde(C_E, 6'b000001);
        go(3'd5, C_W);
        go(3'd6, C_U);

        ir_n = 16'h0A05; nzp_n = 3'b010;
        fde(C_E, 6'b000100);
        go(3'd6, C_U);
        nzp_n = 3'b100;
        fde(C_E, 6'b000100);
        go(3'd6, C_UT);

        ir_n = 16'h6283;
        fde(C_E, 6'b000010);
        mem(1'b0, 3'd3, C_R0);
        mem(1'b0, 3'd3, C_R0);
        mem(1'b0, 3'd3, C_R0);
        mem(1'b1, 3'd3, C_R0);
        go(3'd5, C_W);
        go(3'd6, C_U);

        ir_n = 16'h5042;
        fde(C_E, 6'b010000);
        go(3'd5, C_W);
        go(3'd6, C_U);

        ir_n = 16'h927F;
        fde(C_E, 6'b100000);
        go(3'd5, C_W);
        go(3'd6, C_U);

        ir_n = 16'hC1C0; nzp_n = 3'b000;
        fde(C_E, 6'b001110);
        go(3'd6, C_UT);

        ir_n = 16'h3205;
        fde(C_E, 6'b000100);
        mem(1'b1, 3'd4, C_W0);
        go(3'd6, C_U);

        ir_n = 16'hD000; nzp_n = 3'b111;
        fde(C_EI, 6'b000000);
        go(3'd6, C_U);

        ir_n = 16'hA205;
`ifdef LC3_INDIRECT_EN
        fde(C_E, 6'b000100);
        mem(1'b1, 3'd3, C_R0);
        mem(1'b1, 3'd3, C_R1);
        go(3'd5, C_WA);
        go(3'd6, C_UA);
        step(1'b0, 1'b0, 1'b0, 3'd0, C_0, 6'b0, 1'b0);
        go(3'd0, C_F);
`else
        fde(C_EI, 6'b000100);
        go(3'd6, C_U);
`endif

        ir_n = 16'hB205;
`ifdef LC3_INDIRECT_EN
        fde(C_E, 6'b000100);
        mem(1'b1, 3'd3, C_R0);
        mem(1'b1, 3'd4, C_W1);
        go(3'd6, C_UA);
        step(1'b0, 1'b0, 1'b0, 3'd0, C_0, 6'b0, 1'b0);
        go(3'd0, C_F);
`else
        fde(C_EI, 6'b000100);
        go(3'd6, C_U);
`endif

        ir_n = 16'h2205;
        fde(C_E, 6'b000100);
        mem(1'b0, 3'd3, C_R0);
        mem(1'b0, 3'd3, C_R0);
        step(1'b0, 1'b0, 1'b0, 3'd3, C_0, 6'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 3'd0, C_0, 6'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 3'd0, C_0, 6'b0, 1'b0);
        go(3'd0, C_F);
        step(1'b1, 1'b1, 1'b0, 3'd0, C_F, 6'b0, 1'b0);
        go(3'd1, C_D);

        @(negedge clock);
        #1;
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: pending=%0d, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lc3_controller.md
LC3_CONTROLLER -- requirements
Module: lc3_controller

Interface
REQ-001 SHALL have port: clock  in  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-low (0 = reset); sampled only on the rising edge of clock.
REQ-003 SHALL have port: IR  in  16  current instruction, held stable by Decode from DECODE to end of UPDATE_PC.
REQ-004 SHALL have port: nzp  in  3  PSR condition flags {N,Z,P}.
REQ-005 SHALL have port: imem_ack  in  1  instruction memory complete; sampled in FETCH.
REQ-006 SHALL have port: dmem_ack  in  1  data memory complete; sampled in MEM_RD/MEM_WR.
REQ-007 SHALL have ports: enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC  out  1 each  stage enables.
REQ-008 SHALL have ports: imem_req, dmem_req, dmem_we, dmem_addr_sel  out  1 each  memory handshake; addr_sel 0 = pcout, 1 = fetched pointer.
REQ-009 SHALL have ports: E_control  out  6  Execute control; br_taken  out  1; illegal  out  1; state  out  3.

Function
REQ-010 SHALL implement a Moore FSM, encodings FETCH=0, DECODE=1, EXECUTE=2, MEM_RD=3, MEM_WR=4, WRITEBACK=5, UPDATE_PC=6; 7 SHALL go to FETCH.
REQ-011 FETCH: imem_req=1, enable_fetch=1; stay until imem_ack=1, then DECODE.
REQ-012 DECODE: enable_decode=1 for exactly one cycle, then EXECUTE.
REQ-013 EXECUTE: enable_execute=1 for one cycle; next state by IR[15:12]: ADD/AND/NOT/LEA -> WRITEBACK; LD/LDR/LDI/STI -> MEM_RD; ST/STR -> MEM_WR; BR/JMP -> UPDATE_PC; others -> UPDATE_PC.
REQ-014 MEM_RD/MEM_WR: dmem_req=1 held until dmem_ack=1; dmem_we=1 only in MEM_WR.
REQ-015 A one-bit indirect flag SHALL clear in EXECUTE, set on LDI/STI first-access ack; dmem_addr_sel SHALL equal the flag.
REQ-016 MEM_RD ack: LDI/STI with flag=0 -> MEM_RD (LDI) or MEM_WR (STI); otherwise LD/LDR/LDI -> WRITEBACK. MEM_WR ack -> UPDATE_PC.
REQ-017 WRITEBACK: enable_writeback=1 for one cycle, then UPDATE_PC.
REQ-018 UPDATE_PC: enable_updatePC=1 for one cycle, then FETCH.
REQ-019 br_taken SHALL be 1 only in UPDATE_PC when JMP, or BR with |(IR[11:9] & nzp).
REQ-020 E_control[5:4] alu op (ADD 00, AND 01, NOT 10), [3:2] pc_sel1 (00 offset6, 01 offset9, 10 offset11, 11 zero), [1] pc_sel2 (1 VSR1, 0 npc), [0] op2_sel (1 imm5).
REQ-021 E_control decode: ADD/AND = {op,00,0,IR[5]}; NOT = 100000; LD/ST/LDI/STI/LEA/BR = 000100; LDR/STR = 000010; JMP = 001110; any other opcode = 000000.
REQ-022 E_control SHALL be combinational from IR in all states; only its value during EXECUTE is meaningful.
REQ-023 illegal SHALL pulse 1 in EXECUTE for opcodes 0100, 1000, 1101, 1111 (and LDI/STI when REQ-026 disabled); these retire as NOPs via UPDATE_PC, br_taken=0.
REQ-024 Zero-wait latency (ack on first request cycle): ALU/LEA 5 cycles, BR/JMP/illegal 4, LD/LDR 6, ST/STR 5, LDI 7, STI 6.

Reset
REQ-025 reset=0 at a rising edge SHALL force state=FETCH and indirect flag=0 from any state including mid-memory wait; while reset=0 all outputs except E_control and state SHALL be 0; first cycle after release SHALL assert imem_req=1.

Configuration
REQ-026 Macro LC3_INDIRECT_EN: defined -> LDI/STI two-access behaviour per REQ-015/016; undefined -> flag logic absent, dmem_addr_sel tied 0, LDI/STI treated as illegal NOPs.

Verification
REQ-027 Reset held 3 cycles mid-MEM_RD (dmem_ack=0) -> state=0, all enables 0; release -> imem_req=1 next cycle.
REQ-028 IR=0x1262 (ADD imm), acks immediate -> E_control=000001 in EXECUTE; states 0,1,2,5,6,0 in 5 cycles.
REQ-029 IR=0x0A05 (BRnp), nzp=010 -> br_taken=0; nzp=100 -> br_taken=1 in UPDATE_PC.
REQ-030 IR=0x6283 (LDR), dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, E_control=000010, then WRITEBACK.
REQ-031 IR=0xA205 (LDI) with LC3_INDIRECT_EN -> two MEM_RD accesses, dmem_addr_sel 0 then 1; without macro -> illegal=1, no dmem_req.
REQ-032 IR=0xD000 -> illegal=1 one cycle, enable_writeback never 1, returns to FETCH.
